// File: rtl/fp_div_arbiter.sv
// Shares one fixed-latency divider among NUM_REQ requesters: round-robin issue,
// credit-based flow control and an in-order tag FIFO steering results to per-requester FIFOs.
module fp_div_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 14,
   parameter int DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   output logic [NUM_REQ-1:0]    resp_valid,
   input  logic [NUM_REQ-1:0]    resp_ready,
   output logic [NUM_REQ*32-1:0] resp_data,
   output logic                  div_go,
   output logic [31:0]           div_a,
   output logic [31:0]           div_b,
   input  logic                  div_done,
   input  logic [31:0]           div_result,
   output logic                  err
);
   localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TPW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int TCW = $clog2(LATENCY + 1);
   localparam int RPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RCW = $clog2(DEPTH + 1);

   logic [IW-1:0]      rr;
   logic [TCW-1:0]     drain;
   logic [NUM_REQ-1:0] eligible;
   logic               grant;
   logic [IW-1:0]      gidx;
   logic [31:0]        a_arr [NUM_REQ];
   logic [31:0]        b_arr [NUM_REQ];

   logic [IW-1:0]      tag_mem [LATENCY];
   logic [TPW-1:0]     tag_wr;
   logic [TPW-1:0]     tag_rd;
   logic [TCW-1:0]     tag_cnt;
   logic               tag_empty;
   logic               tag_pop;
   logic [IW-1:0]      tag_head;

   function automatic logic [IW-1:0] rr_add(input logic [IW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IW'(sum);
   endfunction

   function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
      return (p == TPW'(LATENCY - 1)) ? '0 : p + 1'b1;
   endfunction

   // Scan from the highest offset down so the requester closest to rr wins.
   always_comb begin
      grant = 1'b0;
      gidx  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (eligible[rr_add(rr, k)]) begin
            grant = 1'b1;
            gidx  = rr_add(rr, k);
         end
      end
   end

   assign div_go    = grant;
   assign div_a     = grant ? a_arr[gidx] : '0;
   assign div_b     = grant ? b_arr[gidx] : '0;
   assign tag_empty = (tag_cnt == '0);
   assign tag_pop   = div_done && !tag_empty;
   assign tag_head  = tag_mem[tag_rd];

   always_ff @(posedge clock) begin
      if (grant) tag_mem[tag_wr] <= gidx;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tag_wr  <= '0;
         tag_rd  <= '0;
         tag_cnt <= '0;
         rr      <= '0;
         drain   <= TCW'(LATENCY);
         err     <= 1'b0;
      end else begin
         if (grant) begin
            tag_wr <= tag_inc(tag_wr);
            rr     <= rr_add(gidx, 1);
         end
         if (tag_pop) tag_rd <= tag_inc(tag_rd);
         case ({grant, tag_pop})
            2'b10:   tag_cnt <= tag_cnt + 1'b1;
            2'b01:   tag_cnt <= tag_cnt - 1'b1;
            default: ;
         endcase
         if (drain != '0) drain <= drain - 1'b1;
         // Completions during the drain window belong to work issued before reset.
         if (div_done && tag_empty && (drain == '0)) err <= 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         logic [31:0]    fifo_mem [DEPTH];
         logic [RPW-1:0] wr_ptr;
         logic [RPW-1:0] rd_ptr;
         logic [RCW-1:0] occ;
         logic [RCW-1:0] credit;
         logic           wr_en;
         logic           rd_en;
         logic           issue;

         assign a_arr[gi]              = req_a[32*gi +: 32];
         assign b_arr[gi]              = req_b[32*gi +: 32];
         assign eligible[gi]           = req_valid[gi] && (credit != '0) && (drain == '0);
         assign issue                  = grant && (gidx == IW'(gi));
         assign req_ready[gi]          = issue;
         assign wr_en                  = tag_pop && (tag_head == IW'(gi));
         assign resp_valid[gi]         = (occ != '0);
         assign rd_en                  = resp_valid[gi] && resp_ready[gi];
         assign resp_data[32*gi +: 32] = resp_valid[gi] ? fifo_mem[rd_ptr] : '0;

         always_ff @(posedge clock) begin
            if (wr_en) fifo_mem[wr_ptr] <= div_result;
         end

         // Credit covers both in-flight divides and buffered results, so a write never finds the FIFO full.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               occ    <= '0;
               credit <= RCW'(DEPTH);
            end else begin
               if (wr_en) wr_ptr <= (wr_ptr == RPW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
               if (rd_en) rd_ptr <= (rd_ptr == RPW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
               case ({wr_en, rd_en})
                  2'b10:   occ <= occ + 1'b1;
                  2'b01:   occ <= occ - 1'b1;
                  default: ;
               endcase
               case ({issue, rd_en})
                  2'b10:   credit <= credit - 1'b1;
                  2'b01:   credit <= credit + 1'b1;
                  default: ;
               endcase
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: a fixed-latency divider model plus a queue-based
// reference of outstanding work per requester, checked every cycle.
module tb_fp_div_arbiter;
   localparam int N   = 4;
   localparam int LAT = 14;
   localparam int DEP = 4;

   logic            clock = 1'b0;
   logic            reset_n = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_a = '0;
   logic [N*32-1:0] req_b = '0;
   logic [N-1:0]    resp_valid;
   logic [N-1:0]    resp_ready = '0;
   logic [N*32-1:0] resp_data;
   logic            div_go;
   logic [31:0]     div_a;
   logic [31:0]     div_b;
   logic            div_done = 1'b0;
   logic [31:0]     div_result = '0;
   logic            err;

   int n_checks = 0;
   int n_fail   = 0;

   fp_div_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .DEPTH(DEP)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .div_go(div_go), .div_a(div_a), .div_b(div_b),
      .div_done(div_done), .div_result(div_result), .err(err)
   );

   always #5 clock = ~clock;

   function automatic real sp2r(input logic [31:0] x);
      real v;
      int  e;
      e = int'(x[30:23]);
      if (e == 0) return 0.0;
      v = 1.0 + real'(x[22:0]) / 8388608.0;
      for (int k = 0; k < e - 127; k++) v = v * 2.0;
      for (int k = 0; k < 127 - e; k++) v = v / 2.0;
      return x[31] ? -v : v;
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      int          e;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return 32'd0;
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
      return r2sp(sp2r(a) / sp2r(b));
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] x;
      x[31]    = 1'($urandom);
      x[30:23] = 8'(120 + $urandom_range(0, 14));
      x[22:0]  = 23'($urandom);
      return x;
   endfunction

   // Divider: result appears LAT cycles after the go cycle; spur injects a stray done.
   bit          pipe_v [LAT];
   logic [31:0] pipe_r [LAT];
   bit          spur = 1'b0;
   always @(posedge clock) begin
      for (int k = LAT - 1; k > 0; k--) begin
         pipe_v[k] <= pipe_v[k-1];
         pipe_r[k] <= pipe_r[k-1];
      end
      pipe_v[0]  <= div_go;
      pipe_r[0]  <= div_go ? fdiv(div_a, div_b) : 32'h0;
      div_done   <= pipe_v[LAT-2] | spur;
      div_result <= pipe_v[LAT-2] ? pipe_r[LAT-2] : 32'h0;
   end

   // Reference: per requester, the ordered list of results not yet consumed (in flight + buffered).
   int          m_rr;
   int          m_drain;
   bit          m_err;
   logic [31:0] m_res [N][$];
   int          m_vis [N];
   int          m_tags [$];

   logic [N-1:0]    obs_ready;
   logic [N-1:0]    obs_rv;
   logic            obs_go;
   logic            obs_err;
   logic [31:0]     obs_a;
   logic [31:0]     obs_b;
   logic [N*32-1:0] obs_data;

   task automatic model_reset();
      m_rr = 0;
      m_drain = LAT;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_res[i].delete();
         m_vis[i] = 0;
      end
      m_tags.delete();
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         req_a[32*i +: 32] = rand_fp();
         req_b[32*i +: 32] = rand_fp();
      end
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic cycle();
      int           g;
      int           t;
      logic [N-1:0] exp_ready;
      logic [31:0]  ea;
      logic [31:0]  eb;
      #1;
      obs_ready = req_ready;
      obs_go    = div_go;
      obs_rv    = resp_valid;
      obs_err   = err;
      obs_a     = div_a;
      obs_b     = div_b;
      obs_data  = resp_data;
      g = -1;
      if (m_drain == 0) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (g < 0 && req_valid[idx] && m_res[idx].size() < DEP) g = idx;
         end
      end
      exp_ready = '0;
      ea = '0;
      eb = '0;
      if (g >= 0) begin
         exp_ready[g] = 1'b1;
         ea = req_a[32*g +: 32];
         eb = req_b[32*g +: 32];
      end
      n_checks++;
      if (req_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL sb_req_ready: got %b, expected %b", req_ready, exp_ready);
      end
      n_checks++;
      if (div_go !== (g >= 0)) begin
         n_fail++;
         $display("FAIL sb_div_go: got %b, expected %b", div_go, (g >= 0));
      end
      n_checks++;
      if (div_a !== ea || div_b !== eb) begin
         n_fail++;
         $display("FAIL sb_div_ops: got %h/%h, expected %h/%h", div_a, div_b, ea, eb);
      end
      n_checks++;
      if (err !== m_err) begin
         n_fail++;
         $display("FAIL sb_err: got %b, expected %b", err, m_err);
      end
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (resp_valid[i] !== (m_vis[i] > 0)) begin
            n_fail++;
            $display("FAIL sb_resp_valid[%0d]: got %b, expected %b", i, resp_valid[i], (m_vis[i] > 0));
         end else if (m_vis[i] > 0) begin
            n_checks++;
            if (resp_data[32*i +: 32] !== m_res[i][0]) begin
               n_fail++;
               $display("FAIL sb_resp_data[%0d]: got %h, expected %h", i, resp_data[32*i +: 32], m_res[i][0]);
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (m_vis[i] > 0 && resp_ready[i]) begin
            void'(m_res[i].pop_front());
            m_vis[i]--;
         end
      end
      if (div_done === 1'b1) begin
         if (m_tags.size() > 0) begin
            t = m_tags.pop_front();
            m_vis[t]++;
         end else if (m_drain == 0) begin
            m_err = 1'b1;
         end
      end
      if (g >= 0) begin
         m_res[g].push_back(fdiv(ea, eb));
         m_tags.push_back(g);
         m_rr = (g + 1) % N;
      end
      if (m_drain > 0) m_drain--;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      req_valid  = '0;
      resp_ready = '1;
      for (int k = 0; k < n; k++) cycle();
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic test_reset();
      int first;
      #1;
      n_checks++;
      if (req_ready !== '0 || div_go !== 1'b0 || div_a !== '0 || div_b !== '0) begin
         n_fail++;
         $display("FAIL reset_issue: got ready=%b go=%b a=%h b=%h, expected all zero", req_ready, div_go, div_a, div_b);
      end
      n_checks++;
      if (resp_valid !== '0 || resp_data !== '0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_resp: got rv=%b data=%h err=%b, expected all zero", resp_valid, resp_data, err);
      end
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      req_valid  = '1;
      resp_ready = '1;
      rand_ops();
      first = -1;
      for (int k = 0; k < LAT + 10; k++) begin
         cycle();
         if (first < 0 && obs_go) first = k;
      end
      n_checks++;
      if (first != LAT) begin
         n_fail++;
         $display("FAIL reset_drain_first_grant: got cycle %0d, expected %0d", first, LAT);
      end
   endtask

   task automatic test_single();
      int          first;
      logic [31:0] got;
      idle(30);
      req_valid  = 4'b0001;
      resp_ready = '0;
      req_a[31:0] = 32'h40C00000;
      req_b[31:0] = 32'h40000000;
      cycle();
      n_checks++;
      if (obs_go !== 1'b1 || obs_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_issue: got go=%b ready=%b, expected 1/0001", obs_go, obs_ready);
      end
      n_checks++;
      if (obs_a !== 32'h40C00000 || obs_b !== 32'h40000000) begin
         n_fail++;
         $display("FAIL single_ops: got %h/%h, expected 40c00000/40000000", obs_a, obs_b);
      end
      req_valid = '0;
      first = -1;
      got = '0;
      for (int k = 1; k <= 20; k++) begin
         cycle();
         if (first < 0 && obs_rv[0]) begin
            first = k;
            got = obs_data[31:0];
         end
      end
      n_checks++;
      if (first != LAT + 1) begin
         n_fail++;
         $display("FAIL single_latency: got %0d, expected %0d", first, LAT + 1);
      end
      n_checks++;
      if (got !== 32'h40400000) begin
         n_fail++;
         $display("FAIL single_result: got %h, expected 40400000", got);
      end
      idle(5);
   endtask

   task automatic test_round_robin();
      int prev;
      int cur;
      int ngrant;
      idle(30);
      req_valid  = '1;
      resp_ready = '1;
      prev   = -1;
      ngrant = 0;
      for (int k = 0; k < 40; k++) begin
         rand_ops();
         cycle();
         if (obs_go) ngrant++;
         cur = onehot_idx(obs_ready);
         if (prev >= 0) begin
            n_checks++;
            if (cur != (prev + 1) % N) begin
               n_fail++;
               $display("FAIL rr_order: got %0d, expected %0d", cur, (prev + 1) % N);
            end
         end
         prev = cur;
      end
      n_checks++;
      if (ngrant != 40) begin
         n_fail++;
         $display("FAIL rr_throughput: got %0d grants, expected 40", ngrant);
      end
      idle(30);
   endtask

   task automatic test_credit_stall();
      int ngrant;
      idle(30);
      req_valid  = 4'b0100;
      resp_ready = 4'b1011;
      ngrant = 0;
      for (int k = 0; k < 30; k++) begin
         rand_ops();
         cycle();
         if (obs_ready[2]) ngrant++;
      end
      n_checks++;
      if (ngrant != DEP) begin
         n_fail++;
         $display("FAIL stall_grants: got %0d, expected %0d", ngrant, DEP);
      end
      resp_ready = 4'b1111;
      cycle();
      n_checks++;
      if (obs_ready[2] !== 1'b0 || obs_rv[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_pop_cycle: got ready=%b rv=%b, expected 0/1", obs_ready[2], obs_rv[2]);
      end
      resp_ready = 4'b1011;
      ngrant = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (obs_ready[2]) ngrant++;
      end
      n_checks++;
      if (ngrant != 1) begin
         n_fail++;
         $display("FAIL stall_regrant: got %0d, expected 1", ngrant);
      end
      idle(30);
   endtask

   task automatic test_simultaneous();
      logic [3:0] seen;
      idle(30);
      req_valid  = 4'b0010;
      resp_ready = 4'b1101;
      for (int k = 0; k < 25; k++) begin
         rand_ops();
         cycle();
      end
      resp_ready = 4'b1111;
      cycle();
      seen[0] = obs_ready[1];
      n_checks++;
      if (obs_rv[1] !== 1'b1 || seen[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_pop_no_grant: got rv=%b ready=%b, expected 1/0", obs_rv[1], seen[0]);
      end
      cycle();
      seen[1] = obs_ready[1];
      resp_ready = 4'b1101;
      cycle();
      seen[2] = obs_ready[1];
      cycle();
      seen[3] = obs_ready[1];
      n_checks++;
      if (seen[3:1] !== 3'b011) begin
         n_fail++;
         $display("FAIL simul_issue_pop_credit: got %b, expected 011", seen[3:1]);
      end
      idle(30);
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         req_valid  = 4'($urandom);
         resp_ready = 4'($urandom) | 4'($urandom);
         rand_ops();
         cycle();
      end
      idle(30);
      n_checks++;
      if (obs_rv !== '0) begin
         n_fail++;
         $display("FAIL random_drained: got rv=%b, expected 0000", obs_rv);
      end
   endtask

   task automatic test_spurious();
      idle(30);
      resp_ready = '0;
      spur = 1'b1;
      cycle();
      spur = 1'b0;
      n_checks++;
      if (obs_err !== 1'b0) begin
         n_fail++;
         $display("FAIL spur_before: got err=%b, expected 0", obs_err);
      end
      for (int k = 0; k < 6; k++) cycle();
      n_checks++;
      if (obs_err !== 1'b1 || obs_rv !== '0) begin
         n_fail++;
         $display("FAIL spur_after: got err=%b rv=%b, expected 1/0000", obs_err, obs_rv);
      end
   endtask

   task automatic test_reset_midflight();
      int first;
      int ngo;
      req_valid  = '1;
      resp_ready = '1;
      ngo = 0;
      for (int k = 0; k < 5; k++) begin
         rand_ops();
         cycle();
         if (obs_go) ngo++;
      end
      n_checks++;
      if (ngo != 5) begin
         n_fail++;
         $display("FAIL midflight_issued: got %0d, expected 5", ngo);
      end
      req_valid = '0;
      reset_n   = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== '0 || div_go !== 1'b0 || div_a !== '0 || div_b !== '0) begin
         n_fail++;
         $display("FAIL midflight_reset_issue: got ready=%b go=%b a=%h b=%h, expected all zero", req_ready, div_go, div_a, div_b);
      end
      n_checks++;
      if (resp_valid !== '0 || resp_data !== '0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL midflight_reset_resp: got rv=%b data=%h err=%b, expected all zero", resp_valid, resp_data, err);
      end
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      req_valid  = '1;
      resp_ready = '1;
      first = -1;
      for (int k = 0; k < LAT + 16; k++) begin
         rand_ops();
         cycle();
         if (first < 0 && obs_go) first = k;
      end
      n_checks++;
      if (first != LAT) begin
         n_fail++;
         $display("FAIL midflight_first_grant: got cycle %0d, expected %0d", first, LAT);
      end
      n_checks++;
      if (obs_err !== 1'b0) begin
         n_fail++;
         $display("FAIL midflight_stale_err: got err=%b, expected 0", obs_err);
      end
      idle(30);
   endtask

   initial begin
      model_reset();
      #1 reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      test_reset();
      test_single();
      test_round_robin();
      test_credit_stall();
      test_simultaneous();
      test_random();
      test_spurious();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
